// File: rtl/des_keysched_dec.sv
// -----------------------------------------------------------------------------
// des_keysched_dec
//
// Sequential DES key-schedule generator. A 56-bit post-PC-1 key (C0||D0) is
// loaded on start, and the block then hands out one 48-bit PC-2 subkey per
// accepted valid/ready handshake. By default subkeys come out in decryption
// order (K16 first, K1 last), with the C and D halves rotated right between
// rounds.
//
// Optional build macro: DES_KS_ENC_MODE_EN
//   When defined, an extra 'mode' input is sampled together with start.
//   mode=1 selects the encryption schedule (left rotations, K1..K16).
//   mode=0 keeps the decryption behaviour. Timing and handshake are the
//   same in both builds.
//
// Ports:
//   clk      in   1   clock, rising edge
//   rst      in   1   asynchronous active-high reset
//   start    in   1   load key_in and begin a schedule (only while ready=1)
//   key_in   in  56   C0 = key_in[55:28], D0 = key_in[27:0]
//   mode     in   1   (DES_KS_ENC_MODE_EN only) 1 = encryption schedule
//   ready    out  1   idle, a start will be accepted
//   k_valid  out  1   k_out / k_round hold a valid subkey
//   k_ready  in   1   consumer accepts the current subkey
//   k_round  out  4   round index 0..NROUNDS-1 of the current subkey
//   k_out    out 48   PC-2(C,D); bit 47 is PC-2 output bit 1
//   done     out  1   one-cycle pulse after the last subkey is accepted
// -----------------------------------------------------------------------------
module des_keysched_dec #(
  parameter int NROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [55:0] key_in,
`ifdef DES_KS_ENC_MODE_EN
  input  logic        mode,
`endif
  output logic        ready,
  output logic        k_valid,
  input  logic        k_ready,
  output logic [3:0]  k_round,
  output logic [47:0] k_out,
  output logic        done
);

  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      state;
  logic [27:0] c_q;
  logic [27:0] d_q;
  logic        enc_q;
  logic        start_enc;
  logic        handshake;
  logic [3:0]  next_round;
  logic        single_step;
  logic [27:0] c_next;
  logic [27:0] d_next;
  logic [27:0] c_load;
  logic [27:0] d_load;

  // Circular rotation of one 28-bit half: direction by 'left', distance 1 or 2
  // by 'one'. Pure rewiring selected by a small mux.
  function automatic logic [27:0] rot28(input logic [27:0] x,
                                        input logic        left,
                                        input logic        one);
    logic [27:0] r;
    case ({left, one})
      2'b00:   r = {x[1:0], x[27:2]};
      2'b01:   r = {x[0], x[27:1]};
      2'b10:   r = {x[25:0], x[27:26]};
      default: r = {x[26:0], x[27]};
    endcase
    return r;
  endfunction

`ifdef DES_KS_ENC_MODE_EN
  assign start_enc = mode;
`else
  // Decryption-only build: the direction select folds away to right shifts.
  assign start_enc = 1'b0;
  assign enc_q     = 1'b0;
`endif

  // Next-round rotation. Both schedules use a single-bit step on rounds
  // 1, 8 and 15 and a double step otherwise; only the direction differs.
  // The encryption schedule additionally pre-rotates by one at load time so
  // that round 0 already holds C1/D1.
  always_comb begin
    handshake   = k_valid & k_ready;
    next_round  = k_round + 4'd1;
    single_step = (next_round == 4'd1) || (next_round == 4'd8) ||
                  (next_round == 4'd15);
    c_next      = rot28(c_q, enc_q, single_step);
    d_next      = rot28(d_q, enc_q, single_step);
    c_load      = start_enc ? rot28(key_in[55:28], 1'b1, 1'b1) : key_in[55:28];
    d_load      = start_enc ? rot28(key_in[27:0],  1'b1, 1'b1) : key_in[27:0];
  end

  // PC-2 selection straight from the C/D registers. C holds FIPS bits 1..28
  // (bit n at c_q[28-n]) and D holds bits 29..56 (bit n at d_q[56-n]).
  // The eight bits PC-2 discards never appear here.
  assign k_out = {
    c_q[14], c_q[11], c_q[17], c_q[4],  c_q[27], c_q[23],
    c_q[25], c_q[0],  c_q[13], c_q[22], c_q[7],  c_q[18],
    c_q[5],  c_q[9],  c_q[16], c_q[24], c_q[2],  c_q[20],
    c_q[12], c_q[21], c_q[1],  c_q[8],  c_q[15], c_q[26],
    d_q[15], d_q[4],  d_q[25], d_q[19], d_q[9],  d_q[1],
    d_q[26], d_q[16], d_q[5],  d_q[11], d_q[23], d_q[8],
    d_q[12], d_q[7],  d_q[17], d_q[0],  d_q[22], d_q[3],
    d_q[10], d_q[14], d_q[6],  d_q[20], d_q[27], d_q[24]
  };

  // Control FSM and key registers. ready/k_valid are registered alongside
  // the state so they change exactly on the state transition. k_round is
  // cleared on the way back to IDLE so it only ever wraps through IDLE.
  // C/D are left untouched after the last round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      k_round <= '0;
      ready   <= 1'b1;
      k_valid <= 1'b0;
      done    <= 1'b0;
`ifdef DES_KS_ENC_MODE_EN
      enc_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            c_q     <= c_load;
            d_q     <= d_load;
            k_round <= '0;
            ready   <= 1'b0;
            k_valid <= 1'b1;
            state   <= RUN;
`ifdef DES_KS_ENC_MODE_EN
            enc_q   <= start_enc;
`endif
          end
        end
        RUN: begin
          if (handshake) begin
            if (k_round == LAST_ROUND) begin
              k_round <= '0;
              ready   <= 1'b1;
              k_valid <= 1'b0;
              done    <= 1'b1;
              state   <= IDLE;
            end else begin
              k_round <= next_round;
              c_q     <= c_next;
              d_q     <= d_next;
            end
          end
        end
        default: begin
          state   <= IDLE;
          ready   <= 1'b1;
          k_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_keysched_dec.sv
// -----------------------------------------------------------------------------
// tb_des_keysched_dec
//
// Self-checking bench for des_keysched_dec. Expected subkeys come from a
// reference model of the standard FIPS 46-3 schedule (left shifts, K1..K16)
// and are pushed to a scoreboard queue when a key is started; a monitor pops
// and compares them on every handshake. Scenario checks cover reset values,
// latency, stalls, ignored starts, back-to-back starts and mid-run reset.
// -----------------------------------------------------------------------------
module tb_des_keysched_dec;

  localparam logic [55:0] FIPS_KEY  = 56'hF0CCAAF_556678F;
  localparam logic [55:0] OTHER_KEY = 56'h0123456_789ABCD;
  localparam logic [47:0] FIPS_K16  = 48'hCB3D8B0E17F5;
  localparam logic [47:0] FIPS_K1   = 48'h1B02EFFC7072;

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct {
    logic [3:0]  round;
    logic [47:0] key;
  } exp_t;

  exp_t exp_q[$];

  logic        clk;
  logic        rst;
  logic        start;
  logic [55:0] key_in;
  logic        ready;
  logic        k_valid;
  logic        k_ready;
  logic [3:0]  k_round;
  logic [47:0] k_out;
  logic        done;
`ifdef DES_KS_ENC_MODE_EN
  logic        mode;
`endif

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [47:0] last_key = '0;

  des_keysched_dec #(.NROUNDS(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .key_in  (key_in),
`ifdef DES_KS_ENC_MODE_EN
    .mode    (mode),
`endif
    .ready   (ready),
    .k_valid (k_valid),
    .k_ready (k_ready),
    .k_round (k_round),
    .k_out   (k_out),
    .done    (done)
  );

  // Free-running clock and a cycle counter used for latency checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something stalls beyond every bounded wait.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Reference subkey: decryption round r is FIPS round 16-r, encryption
  // round r is FIPS round r+1; halves are shifted left by the cumulative
  // FIPS shift count and then passed through PC-2.
  function automatic logic [47:0] subkey_model(input logic [55:0] key,
                                               input bit enc, input int r);
    int          fr;
    int          total;
    logic [27:0] c;
    logic [27:0] d;
    logic [55:0] cd;
    logic [47:0] k;
    fr    = enc ? r + 1 : 16 - r;
    total = 0;
    for (int i = 0; i < fr; i++) total += SHIFTS[i];
    c = key[55:28];
    d = key[27:0];
    for (int i = 0; i < total; i++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    k  = '0;
    for (int i = 0; i < 48; i++) k[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
    return k;
  endfunction

  // Push the full expected sequence, then pulse start for one cycle.
  // Returns the cycle in which start was high.
  task automatic applyStimulus(input logic [55:0] key, input bit enc,
                               output int t);
    exp_t e;
    t = cyc;
    for (int r = 0; r < 16; r++) begin
      e.round = 4'(r);
      e.key   = subkey_model(key, enc, r);
      exp_q.push_back(e);
    end
    key_in = key;
`ifdef DES_KS_ENC_MODE_EN
    mode   = enc;
`endif
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(output int c);
    c = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitRound(input int r);
    bit hit;
    hit = 0;
    for (int n = 0; n < 100; n++) begin
      if (k_valid && (k_round == 4'(r))) begin
        hit = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!hit) checkOutput("round_timeout", 64'd0, 64'(r));
  endtask

  // Scoreboard monitor: every handshake pops one expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && k_valid && k_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_subkey", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_round", 64'(k_round), 64'(e.round));
        checkOutput("sb_key", 64'(k_out), 64'(e.key));
        if (k_round == 4'd15) last_key = k_out;
      end
    end
  end

  initial begin
    int          t;
    int          t2;
    int          dc;
    logic [47:0] held;

    rst     = 1'b1;
    start   = 1'b0;
    k_ready = 1'b1;
    key_in  = '0;
`ifdef DES_KS_ENC_MODE_EN
    mode    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 64'(ready), 64'd1);
    checkOutput("rst_k_valid", 64'(k_valid), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_k_round", 64'(k_round), 64'd0);
    checkOutput("rst_k_out", 64'(k_out), 64'd0);
    rst = 1'b0;

    $display("[TB] FIPS key, consumer always ready");
    @(negedge clk);
    applyStimulus(FIPS_KEY, 1'b0, t);
    @(negedge clk);
    checkOutput("s1_first_valid", 64'(k_valid), 64'd1);
    checkOutput("s1_first_round", 64'(k_round), 64'd0);
    checkOutput("s1_first_key", 64'(k_out), 64'(FIPS_K16));
    checkOutput("s1_busy_ready", 64'(ready), 64'd0);
    waitDone(dc);
    checkOutput("s1_done_cycle", 64'(dc), 64'(t + 17));
    checkOutput("s1_ready_at_done", 64'(ready), 64'd1);
    checkOutput("s1_last_key", 64'(last_key), 64'(FIPS_K1));
    @(negedge clk);
    checkOutput("s1_done_one_cycle", 64'(done), 64'd0);

    $display("[TB] FIPS key, 5-cycle stall on round 3");
    applyStimulus(FIPS_KEY, 1'b0, t);
    waitRound(3);
    k_ready = 1'b0;
    held    = subkey_model(FIPS_KEY, 1'b0, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("s2_hold_round", 64'(k_round), 64'd3);
      checkOutput("s2_hold_key", 64'(k_out), 64'(held));
      checkOutput("s2_hold_valid", 64'(k_valid), 64'd1);
      @(posedge clk);
    end
    #1 k_ready = 1'b1;
    waitDone(dc);
    checkOutput("s2_done_cycle", 64'(dc), 64'(t + 22));

    $display("[TB] all-ones and all-zeros keys");
    @(negedge clk);
    applyStimulus({56{1'b1}}, 1'b0, t);
    @(negedge clk);
    checkOutput("s3_ones_key", 64'(k_out), 64'hFFFF_FFFF_FFFF);
    waitDone(dc);
    checkOutput("s3_ones_done", 64'(dc), 64'(t + 17));
    @(negedge clk);
    applyStimulus('0, 1'b0, t);
    @(negedge clk);
    checkOutput("s3_zero_key", 64'(k_out), 64'd0);
    waitDone(dc);
    checkOutput("s3_zero_done", 64'(dc), 64'(t + 17));

    $display("[TB] start during RUN ignored, restart in done cycle");
    @(negedge clk);
    applyStimulus(FIPS_KEY, 1'b0, t);
    waitRound(7);
    key_in = {56{1'b1}};
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(dc);
    checkOutput("s4_done_cycle", 64'(dc), 64'(t + 17));
    checkOutput("s4_ready_at_done", 64'(ready), 64'd1);
    applyStimulus(OTHER_KEY, 1'b0, t2);
    @(negedge clk);
    checkOutput("s4_restart_valid", 64'(k_valid), 64'd1);
    checkOutput("s4_restart_round", 64'(k_round), 64'd0);
    waitDone(dc);
    checkOutput("s4_restart_done", 64'(dc), 64'(t2 + 17));

    $display("[TB] reset at round 9, then fresh schedule");
    @(negedge clk);
    applyStimulus(FIPS_KEY, 1'b0, t);
    waitRound(9);
    #2 rst = 1'b1;
    #1;
    checkOutput("s5_rst_k_valid", 64'(k_valid), 64'd0);
    checkOutput("s5_rst_done", 64'(done), 64'd0);
    checkOutput("s5_rst_k_round", 64'(k_round), 64'd0);
    checkOutput("s5_rst_ready", 64'(ready), 64'd1);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    checkOutput("s5_no_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(FIPS_KEY, 1'b0, t);
    @(negedge clk);
    checkOutput("s5_first_key", 64'(k_out), 64'(FIPS_K16));
    waitDone(dc);
    checkOutput("s5_done_cycle", 64'(dc), 64'(t + 17));
    checkOutput("s5_last_key", 64'(last_key), 64'(FIPS_K1));

`ifdef DES_KS_ENC_MODE_EN
    $display("[TB] encryption schedule, FIPS key");
    @(negedge clk);
    applyStimulus(FIPS_KEY, 1'b1, t);
    @(negedge clk);
    checkOutput("enc_first_key", 64'(k_out), 64'(FIPS_K1));
    waitDone(dc);
    checkOutput("enc_done_cycle", 64'(dc), 64'(t + 17));
    checkOutput("enc_last_key", 64'(last_key), 64'(FIPS_K16));
`endif

    @(negedge clk);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/des_keysched_dec.md
Name: des_keysched_dec

Overview:
- Sequential DES decryption key-schedule generator.
- Takes the 56-bit post-PC-1 key (C0||D0) and emits the 16 round subkeys in decryption order (K16 first, K1 last), one per accepted handshake.
- Each 28-bit half is circularly rotated RIGHT between rounds; subkeys are formed by PC-2.
- Sits beside the Feistel round datapath and feeds it one 48-bit subkey per round.

Parameters:
- NROUNDS, 16, number of subkeys emitted per key load; fixed for DES, parameterised only for bench reuse.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request to load key_in and begin a schedule; honoured only when ready=1.
- key_in  input  56  C0 = key_in[55:28], D0 = key_in[27:0]; bit 55 = FIPS PC-1 output bit 1.
- ready  output  1  high in IDLE; block can accept start.
- k_valid  output  1  k_out/k_round hold a valid subkey.
- k_ready  input  1  consumer accepts the current subkey.
- k_round  output  4  decryption round index 0..15 of the current subkey.
- k_out  output  48  PC-2(C,D); bit 47 = FIPS PC-2 output bit 1.
- done  output  1  one-cycle pulse after the round-15 subkey is accepted.

Behaviour:
- Reset (async, rst=1): state=IDLE, C=D=0, k_round=0, k_valid=0, done=0, ready=1. k_out = PC-2(0,0) = 0.
- States: IDLE, RUN.
- IDLE:
  - ready=1, k_valid=0.
  - start=1: latch C<=key_in[55:28], D<=key_in[27:0], k_round<=0, go to RUN.
  - k_valid=1 on the next cycle (latency 1).
- RUN:
  - ready=0, k_valid=1. start is ignored.
  - k_out is combinational PC-2 of the C/D registers. k_out and k_round stay stable while k_valid=1 and k_ready=0.
  - Handshake = k_valid & k_ready in the same cycle.
  - On a handshake with k_round<15: k_round<=k_round+1, then rotate C and D right by 1 if the NEW k_round is in {1,8,15}, else by 2.
  - Round 0 uses C0/D0 unrotated. Total right rotation over rounds 1..15 is 27.
  - On a handshake with k_round=15: go to IDLE, done<=1 for exactly one cycle. C/D are left as is.
- done and ready are both high in the cycle after the final handshake; start is accepted in that cycle.
- Throughput: with k_ready tied high, start at cycle t gives subkeys at t+1..t+16 and done at t+17.
- rst asserted mid-schedule aborts immediately to reset values; no done pulse.
- Rotation is pure wiring plus a 3-way select (0/1/2); there is no arithmetic on key bits. k_round wraps only through IDLE and never counts past 15.

Optional Feature:
- Macro: DES_KS_ENC_MODE_EN.
- When defined:
  - Extra input port mode (1 bit), sampled with start. mode=1 selects the encryption schedule.
  - Encryption schedule: C/D are rotated LEFT before round 0 and on each handshake, by 1 for rounds {0,1,8,15} and 2 otherwise. Subkeys come out K1..K16.
  - mode=0 gives the decryption behaviour above.
- When undefined: no mode port; decryption only. Timing, handshake and reset behaviour are identical in both builds.

Test Plan:
- FIPS key 133457799BBCDFF1, key_in = F0CCAAF_556678F (hex), start 1 cycle, k_ready=1 -> round 0 k_out=CB3D8B0E17F5, round 15 k_out=1B02EFFC7072, done pulses at t+17, ready=1 at t+17.
- Same key with k_ready low for 5 cycles during round 3 -> k_out/k_round=3 held stable throughout; done delayed by exactly 5 cycles.
- key_in all ones / all zeros -> all 16 subkeys FFFFFFFFFFFF / 000000000000; k_round sequence 0..15 with no gaps.
- start pulsed while in RUN at round 7 -> ignored; schedule completes unchanged; second start in the done cycle begins a new schedule at the next cycle.
- rst asserted at round 9 -> k_valid, done and k_round are 0 immediately (before the next edge), ready=1; a fresh start then reproduces the first scenario.
- DES_KS_ENC_MODE_EN defined, mode=1, FIPS key -> round 0 k_out=1B02EFFC7072, round 15 k_out=CB3D8B0E17F5.
